// File: rtl/moore_run_detector_pkg.sv
// Shared encodings for the Moore run-length detector.
//   ST_*   : 2-bit FSM state codes (IDLE, RUN, HIT, HOLD)
//   MODE_* : output mode codes; code 3 is reserved and behaves as LEVEL
package moore_det_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HIT  = 2'd2;
    localparam logic [1:0] ST_HOLD = 2'd3;

    localparam logic [1:0] MODE_LEVEL  = 2'd0;
    localparam logic [1:0] MODE_PULSE  = 2'd1;
    localparam logic [1:0] MODE_REPEAT = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_RUN  = ST_RUN,
        S_HIT  = ST_HIT,
        S_HOLD = ST_HOLD
    } state_t;

endpackage

// File: rtl/moore_run_detector_if.sv
// Control/status bundle of the run detector.
//   en, w, pol, len, mode, clr : sample enable, monitored input, active level,
//                                run length, output mode, hit-count clear
//   z, hit_count               : detect output, saturating hit counter
// master = driver of the controls, slave = the detector.
interface moore_run_detector_if #(
    parameter int unsigned MAX_LEN = 8,
    parameter int unsigned CNT_W   = 8
);
    localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);

    logic             en;
    logic             w;
    logic             pol;
    logic [LEN_W-1:0] len;
    logic [1:0]       mode;
    logic             clr;
    logic             z;
    logic [CNT_W-1:0] hit_count;

    modport master (output en, w, pol, len, mode, clr, input  z, hit_count);
    modport slave  (input  en, w, pol, len, mode, clr, output z, hit_count);

endinterface

// File: rtl/moore_run_detector_sat_counter.sv
// Saturating up-counter with synchronous clear.
//   Clock, Resetn : clock, async active-low reset
//   clr           : force zero; wins over a coincident inc
//   inc           : count one event, held at all-ones once reached
//   q             : registered count
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         Clock,
    input  logic         Resetn,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    // Next count: clear first, then saturating increment.
    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (inc && (q_q != {W{1'b1}})) begin
            q_d = q_q + W'(1);
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/moore_run_detector.sv
// Moore run-length detector: z is high while in HIT, reached after len
// consecutive enabled samples of w at level pol.
//   Clock, Resetn : clock, async active-low reset
//   bus (slave)   : en/w/pol/len/mode/clr controls, z/hit_count status
module moore_run_detector
    import moore_det_pkg::*;
#(
    parameter int unsigned MAX_LEN = 8,
    parameter int unsigned CNT_W   = 8
) (
    input  logic                 Clock,
    input  logic                 Resetn,
    moore_run_detector_if.slave  bus
);

    localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);

    state_t           state_q, state_d;
    logic [LEN_W-1:0] cnt_q,   cnt_d;
    logic [LEN_W-1:0] len_q,   len_d;
    logic [1:0]       mode_q,  mode_d;
    logic             z_q;
    logic [LEN_W-1:0] len_eff_c;
    logic [LEN_W-1:0] cnt_inc_c;
    logic             a_c;
    logic             hit_c;

    assign a_c       = (bus.w == bus.pol);
    assign cnt_inc_c = cnt_q + LEN_W'(1);

    // Clamp requested length into 1..MAX_LEN.
    always_comb begin
        if (bus.len == '0) begin
            len_eff_c = LEN_W'(1);
        end else if (bus.len > LEN_W'(MAX_LEN)) begin
            len_eff_c = LEN_W'(MAX_LEN);
        end else begin
            len_eff_c = bus.len;
        end
    end

    // Next-state, run counter and configuration latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        mode_d  = mode_q;
        hit_c   = 1'b0;

        // Config follows the inputs on every IDLE edge, enabled or not.
        if (state_q == S_IDLE) begin
            len_d  = len_eff_c;
            mode_d = bus.mode;
        end

        if (bus.en) begin
            case (state_q)
                S_IDLE: begin
                    if (a_c) begin
                        if (len_eff_c == LEN_W'(1)) begin
                            state_d = S_HIT;
                            cnt_d   = LEN_W'(1);
                            hit_c   = 1'b1;
                        end else begin
                            state_d = S_RUN;
                            cnt_d   = LEN_W'(1);
                        end
                    end
                end
                S_RUN: begin
                    if (a_c) begin
                        cnt_d = cnt_inc_c;
                        if (cnt_inc_c == len_q) begin
                            state_d = S_HIT;
                            hit_c   = 1'b1;
                        end
                    end else begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end
                end
                S_HIT: begin
                    if (!a_c) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end else if (mode_q == MODE_PULSE) begin
                        state_d = S_HOLD;
                    end else if (mode_q == MODE_REPEAT) begin
                        // Non-overlapping: the hit bit starts the next run.
                        if (len_q == LEN_W'(1)) begin
                            hit_c = 1'b1;
                        end else begin
                            state_d = S_RUN;
                            cnt_d   = LEN_W'(1);
                        end
                    end
                end
                S_HOLD: begin
                    if (!a_c) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            len_q   <= LEN_W'(1);
            mode_q  <= MODE_LEVEL;
            z_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            mode_q  <= mode_d;
            z_q     <= (state_d == S_HIT);
        end
    end

    assign bus.z = z_q;

    sat_counter #(
        .W (CNT_W)
    ) u_hit_cnt (
        .Clock  (Clock),
        .Resetn (Resetn),
        .clr    (bus.clr),
        .inc    (hit_c),
        .q      (bus.hit_count)
    );

endmodule

// File: tb/tb_moore_run_detector.sv
module tb_moore_run_detector;

    logic Clock;
    logic Resetn;
    int   pass_cnt;
    int   total_cnt;

    moore_run_detector_if #(.MAX_LEN(8), .CNT_W(8)) bus  ();
    moore_run_detector_if #(.MAX_LEN(8), .CNT_W(2)) bus2 ();

    moore_run_detector #(.MAX_LEN(8), .CNT_W(8)) u_dut (
        .Clock  (Clock),
        .Resetn (Resetn),
        .bus    (bus)
    );

    moore_run_detector #(.MAX_LEN(8), .CNT_W(2)) u_dut2 (
        .Clock  (Clock),
        .Resetn (Resetn),
        .bus    (bus2)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk_z(input string name, input logic exp);
        // single-purpose sampler kept out; comparisons are inline below
    endtask

    task automatic test_reset();
        Resetn = 1'b1;
        bus.en = 1'b1; bus.w = 1'b0; bus.pol = 1'b1; bus.len = 4'd1;
        bus.mode = 2'd0; bus.clr = 1'b0;
        bus2.en = 1'b1; bus2.w = 1'b0; bus2.pol = 1'b1; bus2.len = 4'd1;
        bus2.mode = 2'd2; bus2.clr = 1'b0;
        #2 Resetn = 1'b0;
        #2;
        total_cnt++;
        if (bus.z !== 1'b0) $display("FAIL reset_z got %b want 0", bus.z); else pass_cnt++;
        total_cnt++;
        if (bus.hit_count !== 8'd0) $display("FAIL reset_hit got %0d want 0", bus.hit_count); else pass_cnt++;
        total_cnt++;
        if (bus2.hit_count !== 2'd0) $display("FAIL reset_hit2 got %0d want 0", bus2.hit_count); else pass_cnt++;
        step();
        step();
        Resetn = 1'b1;
        step();
        total_cnt++;
        if (bus.z !== 1'b0) $display("FAIL reset_idle_z got %b want 0", bus.z); else pass_cnt++;
    endtask

    task automatic test_level();
        bus.mode = 2'd0; bus.len = 4'd2; bus.pol = 1'b1;
        bus.w = 1'b0; bus.clr = 1'b1;
        step();
        bus.clr = 1'b0; bus.w = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            step();
            total_cnt++;
            if (bus.z !== (i >= 2)) $display("FAIL level_z edge%0d got %b want %b", i, bus.z, (i >= 2));
            else pass_cnt++;
        end
        bus.w = 1'b0;
        step();
        total_cnt++;
        if (bus.z !== 1'b0) $display("FAIL level_drop_z got %b want 0", bus.z); else pass_cnt++;
        total_cnt++;
        if (bus.hit_count !== 8'd1) $display("FAIL level_hit got %0d want 1", bus.hit_count); else pass_cnt++;
    endtask

    task automatic test_pulse();
        bus.mode = 2'd1; bus.len = 4'd3; bus.w = 1'b0; bus.clr = 1'b1;
        step();
        bus.clr = 1'b0; bus.w = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            step();
            total_cnt++;
            if (bus.z !== (i == 3)) $display("FAIL pulse_z edge%0d got %b want %b", i, bus.z, (i == 3));
            else pass_cnt++;
        end
        total_cnt++;
        if (bus.hit_count !== 8'd1) $display("FAIL pulse_hit1 got %0d want 1", bus.hit_count); else pass_cnt++;
        bus.w = 1'b0;
        step();
        bus.w = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            step();
            total_cnt++;
            if (bus.z !== (i == 3)) $display("FAIL pulse2_z edge%0d got %b want %b", i, bus.z, (i == 3));
            else pass_cnt++;
        end
        total_cnt++;
        if (bus.hit_count !== 8'd2) $display("FAIL pulse_hit2 got %0d want 2", bus.hit_count); else pass_cnt++;
        bus.w = 1'b0;
        step();
    endtask

    task automatic test_repeat();
        bus.mode = 2'd2; bus.len = 4'd3; bus.w = 1'b0; bus.clr = 1'b1;
        step();
        bus.clr = 1'b0; bus.w = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            step();
            total_cnt++;
            if (bus.z !== (i % 3 == 0)) $display("FAIL repeat_z edge%0d got %b want %b", i, bus.z, (i % 3 == 0));
            else pass_cnt++;
        end
        total_cnt++;
        if (bus.hit_count !== 8'd3) $display("FAIL repeat_hit got %0d want 3", bus.hit_count); else pass_cnt++;
        bus.w = 1'b0; bus.len = 4'd1; bus.clr = 1'b1;
        step();
        bus.clr = 1'b0; bus.w = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            step();
            total_cnt++;
            if (bus.z !== 1'b1) $display("FAIL repeat1_z edge%0d got %b want 1", i, bus.z); else pass_cnt++;
        end
        total_cnt++;
        if (bus.hit_count !== 8'd4) $display("FAIL repeat1_hit got %0d want 4", bus.hit_count); else pass_cnt++;
        bus.w = 1'b0;
        step();
    endtask

    task automatic test_enable();
        bus.mode = 2'd0; bus.len = 4'd3; bus.w = 1'b0; bus.clr = 1'b1;
        step();
        bus.clr = 1'b0; bus.w = 1'b1;
        step();
        step();
        bus.en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.w = i[0];
            step();
            total_cnt++;
            if (bus.z !== 1'b0) $display("FAIL en_hold_z edge%0d got %b want 0", i, bus.z); else pass_cnt++;
        end
        bus.en = 1'b1; bus.w = 1'b1;
        step();
        total_cnt++;
        if (bus.z !== 1'b1) $display("FAIL en_resume_z got %b want 1", bus.z); else pass_cnt++;
        total_cnt++;
        if (bus.hit_count !== 8'd1) $display("FAIL en_hit got %0d want 1", bus.hit_count); else pass_cnt++;
        bus.w = 1'b0;
        step();
    endtask

    task automatic test_len_latch();
        bus.mode = 2'd0; bus.len = 4'd4; bus.w = 1'b0;
        step();
        bus.w = 1'b1;
        step();
        bus.len = 4'd2;
        for (int i = 2; i <= 4; i++) begin
            step();
            total_cnt++;
            if (bus.z !== (i == 4)) $display("FAIL latch_z edge%0d got %b want %b", i, bus.z, (i == 4));
            else pass_cnt++;
        end
        bus.w = 1'b0;
        step();
        bus.w = 1'b1;
        for (int i = 1; i <= 2; i++) begin
            step();
            total_cnt++;
            if (bus.z !== (i == 2)) $display("FAIL latch2_z edge%0d got %b want %b", i, bus.z, (i == 2));
            else pass_cnt++;
        end
        bus.w = 1'b0;
        step();
    endtask

    task automatic test_len_clamp();
        bus.mode = 2'd0; bus.len = 4'd15; bus.w = 1'b0;
        step();
        bus.w = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            step();
            total_cnt++;
            if (bus.z !== (i == 8)) $display("FAIL clamp_z edge%0d got %b want %b", i, bus.z, (i == 8));
            else pass_cnt++;
        end
        bus.w = 1'b0;
        step();
    endtask

    task automatic test_pol_zero();
        bus.mode = 2'd0; bus.pol = 1'b0; bus.len = 4'd0; bus.w = 1'b1;
        step();
        total_cnt++;
        if (bus.z !== 1'b0) $display("FAIL pol0_idle_z got %b want 0", bus.z); else pass_cnt++;
        bus.w = 1'b0;
        step();
        total_cnt++;
        if (bus.z !== 1'b1) $display("FAIL pol0_hit_z got %b want 1", bus.z); else pass_cnt++;
        bus.w = 1'b1;
        step();
        total_cnt++;
        if (bus.z !== 1'b0) $display("FAIL pol0_exit_z got %b want 0", bus.z); else pass_cnt++;
        bus.pol = 1'b1; bus.w = 1'b0;
        step();
    endtask

    task automatic test_reset_mid_hit();
        bus.mode = 2'd0; bus.len = 4'd1; bus.w = 1'b1;
        step();
        total_cnt++;
        if (bus.z !== 1'b1) $display("FAIL rst_pre_z got %b want 1", bus.z); else pass_cnt++;
        Resetn = 1'b0;
        #1;
        total_cnt++;
        if (bus.z !== 1'b0) $display("FAIL rst_async_z got %b want 0", bus.z); else pass_cnt++;
        total_cnt++;
        if (bus.hit_count !== 8'd0) $display("FAIL rst_async_hit got %0d want 0", bus.hit_count); else pass_cnt++;
        #1;
        Resetn = 1'b1;
        bus.w = 1'b0;
        step();
    endtask

    task automatic test_saturation();
        bus2.mode = 2'd2; bus2.len = 4'd1; bus2.w = 1'b0; bus2.clr = 1'b1;
        step();
        bus2.clr = 1'b0; bus2.w = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            step();
            total_cnt++;
            if (bus2.hit_count !== 2'((i > 3) ? 3 : i))
                $display("FAIL sat_hit edge%0d got %0d want %0d", i, bus2.hit_count, (i > 3) ? 3 : i);
            else pass_cnt++;
        end
        bus2.w = 1'b0;
        step();
    endtask

    task automatic test_clr();
        bus.mode = 2'd2; bus.len = 4'd1; bus.w = 1'b0; bus.clr = 1'b0;
        step();
        bus.w = 1'b1; bus.clr = 1'b1;
        step();
        total_cnt++;
        if (bus.z !== 1'b1) $display("FAIL clr_hit_z got %b want 1", bus.z); else pass_cnt++;
        total_cnt++;
        if (bus.hit_count !== 8'd0) $display("FAIL clr_coincident got %0d want 0", bus.hit_count); else pass_cnt++;
        bus.clr = 1'b0;
        step();
        total_cnt++;
        if (bus.hit_count !== 8'd1) $display("FAIL clr_after got %0d want 1", bus.hit_count); else pass_cnt++;
        bus.en = 1'b0; bus.clr = 1'b1;
        step();
        total_cnt++;
        if (bus.hit_count !== 8'd0) $display("FAIL clr_no_en got %0d want 0", bus.hit_count); else pass_cnt++;
        bus.en = 1'b1; bus.clr = 1'b0; bus.w = 1'b0;
        step();
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        test_reset();
        test_level();
        test_pulse();
        test_repeat();
        test_enable();
        test_len_latch();
        test_len_clamp();
        test_pol_zero();
        test_reset_mid_hit();
        test_saturation();
        test_clr();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
